// File: rtl/seq_subtractor.sv
// seq_subtractor: 64-bit A - B computed W bits per clock,
// with the borrow carried between cycles in a register.
module seq_subtractor #(
   parameter int W = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [63:0] A,
   input  logic [63:0] B,
   output logic        BUSY,
   output logic        DONE,
   output logic [63:0] DIFF,
   output logic        BORROW,
   output logic        OVERFLOW
);

   localparam int N  = 64 / W;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [63:0]   a_q, a_d;
   logic [63:0]   b_q, b_d;
   logic [63:0]   diff_q, diff_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          brw_q, brw_d;
   logic          borrow_q, borrow_d;
   logic          ovf_q, ovf_d;

   logic [W-1:0]  a_c;
   logic [W-1:0]  b_c;
   logic [W:0]    sub;
   logic [W-1:0]  d;
   logic          b_out;
   logic          last;
   logic [63:0]   diff_ins;

   // Select the operand chunk addressed by the current index.
   always_comb begin
      a_c = '0;
      b_c = '0;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IW'(k)) begin
            a_c = a_q[k*W +: W];
            b_c = b_q[k*W +: W];
         end
      end
   end

   assign sub   = {1'b0, a_c} - {1'b0, b_c} - {{W{1'b0}}, brw_q};
   assign d     = sub[W-1:0];
   assign b_out = sub[W];
   assign last  = (idx_q == IW'(N - 1));

   // Merge the freshly computed chunk into its slot of the result.
   always_comb begin
      diff_ins = diff_q;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IW'(k)) begin
            diff_ins[k*W +: W] = d;
         end
      end
   end

   // Next-state logic for the IDLE -> RUN -> FIN sequence.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      idx_d    = idx_q;
      brw_d    = brw_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               a_d     = A;
               b_d     = B;
               brw_d   = 1'b0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            diff_d = diff_ins;
            brw_d  = b_out;
            idx_d  = idx_q + IW'(1);
            if (last) begin
               idx_d    = '0;
               borrow_d = b_out;
               ovf_d    = (a_q[63] != b_q[63]) && (d[W-1] != a_q[63]);
               state_d  = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         idx_q    <= '0;
         brw_q    <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         idx_q    <= idx_d;
         brw_q    <= brw_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign BUSY     = (state_q != S_IDLE);
   assign DONE     = (state_q == S_FIN);
   assign DIFF     = diff_q;
   assign BORROW   = borrow_q;
   assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: scoreboard bench for seq_subtractor
// at chunk widths 8, 1 and 64.
module tb_seq_subtractor;

   typedef struct packed {
      logic [63:0] diff;
      logic        brw;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] a, b;
   logic [2:0]  st;
   int          sel;

   logic        busy8, done8, brw8, ovf8;
   logic        busy1, done1, brw1, ovf1;
   logic        busy64, done64, brw64, ovf64;
   logic [63:0] diff8, diff1, diff64;

   logic        busy_s, done_s, brw_s, ovf_s;
   logic [63:0] diff_s;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   dc8 = 0;
   int   nlat[3] = '{8, 64, 1};

   always #5 clk = ~clk;

   seq_subtractor #(.W(8)) dut8 (
      .CLK(clk), .RST(rst), .START(st[0]), .A(a), .B(b),
      .BUSY(busy8), .DONE(done8), .DIFF(diff8),
      .BORROW(brw8), .OVERFLOW(ovf8)
   );

   seq_subtractor #(.W(1)) dut1 (
      .CLK(clk), .RST(rst), .START(st[1]), .A(a), .B(b),
      .BUSY(busy1), .DONE(done1), .DIFF(diff1),
      .BORROW(brw1), .OVERFLOW(ovf1)
   );

   seq_subtractor #(.W(64)) dut64 (
      .CLK(clk), .RST(rst), .START(st[2]), .A(a), .B(b),
      .BUSY(busy64), .DONE(done64), .DIFF(diff64),
      .BORROW(brw64), .OVERFLOW(ovf64)
   );

   always_comb begin
      busy_s = busy8;
      done_s = done8;
      diff_s = diff8;
      brw_s  = brw8;
      ovf_s  = ovf8;
      if (sel == 1) begin
         busy_s = busy1;
         done_s = done1;
         diff_s = diff1;
         brw_s  = brw1;
         ovf_s  = ovf1;
      end else if (sel == 2) begin
         busy_s = busy64;
         done_s = done64;
         diff_s = diff64;
         brw_s  = brw64;
         ovf_s  = ovf64;
      end
   end

   always @(negedge clk) begin
      if (done8 === 1'b1) dc8++;
   end

   function automatic exp_t model(input logic [63:0] x, input logic [63:0] y);
      exp_t e;
      e.diff = x - y;
      e.brw  = (x < y);
      e.ovf  = (x[63] != y[63]) && (e.diff[63] != x[63]);
      return e;
   endfunction

   task automatic launch(input int s, input logic [63:0] aa,
                         input logic [63:0] bb, input bit push);
      @(negedge clk);
      sel = s;
      a = aa;
      b = bb;
      st = 3'b001 << s;
      if (push) sbq.push_back(model(aa, bb));
      @(negedge clk);
      st = '0;
   endtask

   task automatic wait_done(input int limit, output int j, output int bn);
      j = 0;
      bn = 0;
      forever begin
         if (busy_s === 1'b1) bn++;
         if (done_s === 1'b1) break;
         if (j >= limit) break;
         @(negedge clk);
         j++;
      end
   endtask

   task automatic pop_exp(output exp_t e);
      if (sbq.size() == 0) begin
         e = '0;
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_empty: got no entry, required one");
      end else begin
         e = sbq.pop_front();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      st = '0;
      a = '0;
      b = '0;
      sel = 0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({busy8, done8, diff8, brw8, ovf8} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset_w8: got %h required 0",
                  {busy8, done8, diff8, brw8, ovf8});
      end
      n_tests++;
      if ({busy1, done1, diff1, brw1, ovf1} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset_w1: got %h required 0",
                  {busy1, done1, diff1, brw1, ovf1});
      end
      n_tests++;
      if ({busy64, done64, diff64, brw64, ovf64} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset_w64: got %h required 0",
                  {busy64, done64, diff64, brw64, ovf64});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int j, bn;
      exp_t e;
      launch(0, 64'd5, 64'd3, 1'b1);
      a = 64'hDEAD_BEEF_0000_1234;
      b = 64'h0123_4567_89AB_CDEF;
      wait_done(200, j, bn);
      n_tests++;
      if (j !== 8) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d required 8", j);
      end
      n_tests++;
      if (bn !== 9) begin
         n_fail++;
         $display("FAIL basic_busy_cycles: got %0d required 9", bn);
      end
      pop_exp(e);
      n_tests++;
      if ({diff_s, brw_s, ovf_s} !== {e.diff, e.brw, e.ovf}) begin
         n_fail++;
         $display("FAIL basic_result: got %h/%b/%b required %h/%b/%b",
                  diff_s, brw_s, ovf_s, e.diff, e.brw, e.ovf);
      end
      @(negedge clk);
      n_tests++;
      if ({busy_s, done_s} !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_done_pulse: got busy/done %b required 00",
                  {busy_s, done_s});
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if ({diff_s, brw_s, ovf_s} !== {64'd2, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_hold: got %h/%b/%b required 2/0/0",
                  diff_s, brw_s, ovf_s);
      end
   endtask

   task automatic test_corner(input string nm, input logic [63:0] aa,
                              input logic [63:0] bb);
      int j, bn;
      exp_t e;
      launch(0, aa, bb, 1'b1);
      wait_done(200, j, bn);
      pop_exp(e);
      n_tests++;
      if (done_s !== 1'b1 ||
          {diff_s, brw_s, ovf_s} !== {e.diff, e.brw, e.ovf}) begin
         n_fail++;
         $display("FAIL %s: got %h/%b/%b required %h/%b/%b", nm,
                  diff_s, brw_s, ovf_s, e.diff, e.brw, e.ovf);
      end
   endtask

   task automatic test_ripple_widths();
      int j, bn;
      exp_t e;
      for (int s = 0; s < 3; s++) begin
         launch(s, 64'h0000_0001_0000_0000, 64'd1, 1'b1);
         wait_done(200, j, bn);
         n_tests++;
         if (j !== nlat[s]) begin
            n_fail++;
            $display("FAIL ripple_latency_%0d: got %0d required %0d",
                     s, j, nlat[s]);
         end
         pop_exp(e);
         n_tests++;
         if ({diff_s, brw_s, ovf_s} !== {64'h0000_0000_FFFF_FFFF, 2'b00}) begin
            n_fail++;
            $display("FAIL ripple_result_%0d: got %h/%b/%b required ffffffff/0/0",
                     s, diff_s, brw_s, ovf_s);
         end
         @(negedge clk);
      end
      sel = 0;
   endtask

   task automatic test_start_busy();
      int j, bn, c0;
      exp_t e;
      c0 = dc8;
      launch(0, 64'd10, 64'd4, 1'b1);
      repeat (3) @(negedge clk);
      a = 64'd100;
      b = 64'd1;
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      wait_done(200, j, bn);
      n_tests++;
      if (j + 4 !== 8) begin
         n_fail++;
         $display("FAIL busy_latency: got %0d required 8", j + 4);
      end
      pop_exp(e);
      n_tests++;
      if ({diff_s, brw_s, ovf_s} !== {e.diff, e.brw, e.ovf}) begin
         n_fail++;
         $display("FAIL busy_result: got %h required %h", diff_s, e.diff);
      end
      repeat (12) @(negedge clk);
      n_tests++;
      if (dc8 - c0 !== 1) begin
         n_fail++;
         $display("FAIL busy_done_count: got %0d required 1", dc8 - c0);
      end
   endtask

   task automatic test_reset_mid();
      int j, bn, c0;
      exp_t e;
      c0 = dc8;
      launch(0, 64'd10, 64'd4, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({busy8, done8, diff8, brw8, ovf8} !== 68'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %h required 0",
                  {busy8, done8, diff8, brw8, ovf8});
      end
      rst = 1'b0;
      sbq.delete();
      repeat (12) @(negedge clk);
      n_tests++;
      if (dc8 !== c0) begin
         n_fail++;
         $display("FAIL midreset_no_done: got %0d pulses required 0", dc8 - c0);
      end
      launch(0, 64'd7, 64'd7, 1'b1);
      wait_done(200, j, bn);
      pop_exp(e);
      n_tests++;
      if (done_s !== 1'b1 || {diff_s, brw_s, ovf_s} !== 66'd0) begin
         n_fail++;
         $display("FAIL midreset_after: got %h/%b/%b required 0/0/0",
                  diff_s, brw_s, ovf_s);
      end
   endtask

   task automatic test_random();
      int j, bn;
      exp_t e;
      logic [63:0] x, y;
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 5; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i == 0) y = x;
            if (i == 1) begin
               x = 64'h7FFF_FFFF_FFFF_FFFF;
               y = 64'h8000_0000_0000_0000;
            end
            launch(s, x, y, 1'b1);
            wait_done(200, j, bn);
            n_tests++;
            if (j !== nlat[s]) begin
               n_fail++;
               $display("FAIL rand_latency_%0d_%0d: got %0d required %0d",
                        s, i, j, nlat[s]);
            end
            pop_exp(e);
            n_tests++;
            if ({diff_s, brw_s, ovf_s} !== {e.diff, e.brw, e.ovf}) begin
               n_fail++;
               $display("FAIL rand_result_%0d_%0d: got %h/%b/%b required %h/%b/%b",
                        s, i, diff_s, brw_s, ovf_s, e.diff, e.brw, e.ovf);
            end
            @(negedge clk);
         end
      end
      sel = 0;
   endtask

   task automatic test_back_to_back();
      int j, bn, g;
      exp_t e;
      @(negedge clk);
      sel = 0;
      a = 64'h1234_5678_9ABC_DEF0;
      b = 64'h0FED_CBA9_8765_4321;
      sbq.push_back(model(a, b));
      sbq.push_back(model(a, b));
      st[0] = 1'b1;
      @(negedge clk);
      wait_done(200, j, bn);
      pop_exp(e);
      n_tests++;
      if (done_s !== 1'b1 || {diff_s, brw_s, ovf_s} !== {e.diff, e.brw, e.ovf}) begin
         n_fail++;
         $display("FAIL b2b_first: got %h required %h", diff_s, e.diff);
      end
      g = 0;
      do begin
         @(negedge clk);
         g++;
         if (g == 2) st[0] = 1'b0;
      end while (done_s !== 1'b1 && g < 50);
      st[0] = 1'b0;
      n_tests++;
      if (g !== 10) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d required 10", g);
      end
      pop_exp(e);
      n_tests++;
      if ({diff_s, brw_s, ovf_s} !== {e.diff, e.brw, e.ovf}) begin
         n_fail++;
         $display("FAIL b2b_second: got %h required %h", diff_s, e.diff);
      end
      repeat (12) @(negedge clk);
      n_tests++;
      if (busy8 !== 1'b0 || sbq.size() !== 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got busy=%b queue=%0d required 0/0",
                  busy8, sbq.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corner("underflow", 64'd0, 64'd1);
      test_corner("overflow", 64'h8000_0000_0000_0000, 64'd1);
      test_ripple_widths();
      test_start_busy();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_subtractor.md
Name: seq_subtractor

Overview:
Multi-cycle 64-bit subtractor computing DIFF = A - B, the inverse operation of the team's 64-bit ripple adder. It processes W bits per clock and ripples the borrow across cycles through a registered borrow flop, trading latency for a short critical path. A START/BUSY/DONE handshake lets a controller launch an operation and collect the result. It also reports unsigned borrow and signed overflow.

Parameters:
W, 8, chunk width in bits per cycle; legal values are 1, 2, 4, 8, 16, 32, 64.
N, 64/W, number of chunk cycles (derived localparam, not overridable).

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
START  input  1  launch request; sampled only in IDLE
A  input  64  minuend; captured on accepted START
B  input  64  subtrahend; captured on accepted START
BUSY  output  1  high in RUN and FIN states
DONE  output  1  one-cycle pulse: result valid
DIFF  output  64  A - B mod 2^64; held until the next accepted START
BORROW  output  1  1 iff unsigned A < B
OVERFLOW  output  1  signed two's-complement overflow of A - B

Behaviour:
- Reset: on a rising CLK edge with RST=1, go to state IDLE and clear everything: BUSY=0, DONE=0, DIFF=0, BORROW=0, OVERFLOW=0, chunk index=0, borrow flop=0. Reset has priority over START. Reset mid-operation aborts the operation with no DONE pulse.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - START=1 at an edge: latch A and B into operand registers, borrow flop=0, index=0, go to RUN.
  - START=0: stay in IDLE.
- RUN: each edge computes chunk i = index as {b_out, d[W-1:0]} = A[i*W +: W] - B[i*W +: W] - borrow, with (W+1)-bit zero-extended arithmetic.
  - Write d into DIFF[i*W +: W], set borrow flop = b_out, increment index.
  - When i = N-1: go to FIN, set BORROW = b_out, set OVERFLOW = (A[63] != B[63]) && (d[W-1] != A[63]) using the latched operands, and set DONE=1.
- FIN: lasts exactly one cycle with DONE=1 and BUSY=1. The next edge goes to IDLE with DONE=0.
- Latency: if START is accepted at edge k, DONE is high for the single cycle following edge k+N. With W=8 that is 8 edges; with W=64 it is 1 edge. Throughput is one operation per N+2 cycles.
- START while BUSY=1 (RUN or FIN) is ignored. The operand registers do not change. A and B input changes after acceptance have no effect.
- DIFF, BORROW and OVERFLOW are stable from the DONE cycle until the next accepted START. DIFF chunks update progressively during RUN; consumers use them only when DONE=1.
- Arithmetic rule: DIFF equals (A + ~B + 1) mod 2^64 for all inputs. BORROW is the inverse of that sum's carry-out.

Test Plan:
- Basic subtraction (W=8): after reset, pulse START with A=5, B=3 -> BUSY=1 for 9 cycles; DONE pulses 8 edges after acceptance; DIFF=0x0000000000000002, BORROW=0, OVERFLOW=0.
- Unsigned underflow: A=0, B=1 -> DIFF=0xFFFFFFFFFFFFFFFF, BORROW=1, OVERFLOW=0.
- Signed overflow: A=0x8000000000000000, B=1 -> DIFF=0x7FFFFFFFFFFFFFFF, BORROW=0, OVERFLOW=1.
- Borrow ripple across chunks:
  - W=8: A=0x0000000100000000, B=1 -> DIFF=0x00000000FFFFFFFF, BORROW=0.
  - Repeat at W=1 (DONE after 64 edges) and W=64 (DONE after 1 edge) with identical results.
- START while busy: start A=10, B=4. Three cycles later assert START with A=100, B=1 -> second START ignored; DIFF=6, exactly one DONE pulse.
- Reset mid-operation: start A=10, B=4, assert RST at edge 4 -> all outputs 0, no DONE. A new START with A=7, B=7 -> DIFF=0, BORROW=0, OVERFLOW=0.
